// File: rtl/counter_pkg.sv
// Shared types and constants for the 8-bit counter / binary-to-BCD display path.
package counter_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ctrl_state_t;

    localparam int BCD_DIGIT_W = 4;

    // Smallest number of decimal digits that can show every unsigned value of the given width.
    function automatic int bcd_digits(input int width);
        longint max_val;
        longint span;
        int     n;
        max_val = (longint'(1) << width) - 1;
        span    = 10;
        n       = 1;
        while (span <= max_val) begin
            span = span * 10;
            n    = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/counter_ctrl_bcd_serial.sv
// Iterative shift/add-3 (double-dabble) binary-to-BCD engine: one iteration per clk,
// a capture at any time restarts the conversion with the newest value.
module bcd_serial
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          capture,
    input  logic [WIDTH-1:0]              x,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          done,
    output logic                          busy
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int IW = $clog2(WIDTH + 1);

    logic [SW-1:0] sr_q, sr_d, step;
    logic [IW-1:0] iter_q, iter_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Shift register layout is {bcd digits, remaining binary bits}.
    function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W] >= 4'd5)
                r[WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W] =
                    r[WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W] + 4'd3;
        end
        return r << 1;
    endfunction

    always_comb begin
        step   = dabble(sr_q);
        sr_d   = sr_q;
        iter_d = iter_q;
        busy_d = busy_q;
        done_d = 1'b0;
        bcd_d  = bcd_q;
        if (capture) begin
            sr_d   = {{BW{1'b0}}, x};
            iter_d = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d   = step;
            iter_d = iter_q + 1'b1;
            if (iter_q == IW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                bcd_d  = step[SW-1 -: BW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
        end else begin
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
            bcd_q  <= bcd_d;
        end
    end

    // Working register is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign bcd  = bcd_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller: start/stop/load FSM, prescaled count register and BCD conversion
// scheduling. Define COUNTER_CTRL_SATURATE_EN to hold at the maximum count instead of wrapping.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = bcd_digits(WIDTH),
    parameter int PRESCALE = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          load,
    input  logic [WIDTH-1:0]              v,
    output logic [WIDTH-1:0]              count,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          bcd_valid,
    output logic                          busy,
    output logic                          running,
    output logic                          tc
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    ctrl_state_t      state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             tick, sat_hit, capture;

    always_comb begin
        tick    = (state_q == RUN) && (presc_q == PRE_LAST);
        sat_hit = 1'b0;
        count_d = count_q;
        if (load) begin
            count_d = v;
        end else if (tick) begin
`ifdef COUNTER_CTRL_SATURATE_EN
            if (count_q == '1)
                sat_hit = 1'b1;
            else
                count_d = count_q + 1'b1;
`else
            count_d = count_q + 1'b1;
`endif
        end
        tc_d    = tick && !load && (count_q == '1);
        // A load of the unchanged value must still refresh the display.
        capture = load || (count_d != count_q);

        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_d = RUN;
            RUN:     if (stop || sat_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load || tick || state_q != RUN || state_d != RUN)
            presc_d = '0;
        else
            presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    bcd_serial #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .x       (count_d),
        .bcd     (bcd),
        .done    (bcd_valid),
        .busy    (busy)
    );

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign tc      = tc_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: one instance at PRESCALE=9, one at PRESCALE=2, shared stimulus.
module tb_counter_ctrl;

    localparam int W  = 8;
    localparam int PA = 9;
    localparam int PB = 2;

    typedef struct {
        logic [11:0] bcd;
        int          due;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         stop  = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] v     = '0;

    logic [W-1:0] count_a, count_b;
    logic [11:0]  bcd_a, bcd_b;
    logic         valid_a, valid_b, busy_a, busy_b, run_a, run_b, tc_a, tc_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int tc_cnt_a = 0;
    int tc_last_a = -1;
    int nvalid_a = 0;
    int nvalid_b = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    counter_ctrl #(.WIDTH(W), .DIGITS(3), .PRESCALE(PA)) dut_a (
        .clk(clk), .rst(rst_n), .start(start), .stop(stop), .load(load), .v(v),
        .count(count_a), .bcd(bcd_a), .bcd_valid(valid_a), .busy(busy_a),
        .running(run_a), .tc(tc_a)
    );

    counter_ctrl #(.WIDTH(W), .DIGITS(3), .PRESCALE(PB)) dut_b (
        .clk(clk), .rst(rst_n), .start(start), .stop(stop), .load(load), .v(v),
        .count(count_b), .bcd(bcd_b), .bcd_valid(valid_b), .busy(busy_b),
        .running(run_b), .tc(tc_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (tc_a) begin
            tc_cnt_a++;
            tc_last_a = cyc;
        end
        if (valid_a) nvalid_a++;
        if (valid_b) nvalid_b++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] to_bcd(input int n);
        logic [11:0] r;
        r[11:8] = 4'(n / 100);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic until_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_exp(input bit inst_b, input int val, input int due);
        exp_t e;
        e.bcd = to_bcd(val);
        e.due = due;
        if (inst_b) q_b.push_back(e);
        else        q_a.push_back(e);
    endtask

    // Called at a negedge; the load takes effect on the next posedge.
    task automatic do_load(input int val, input bit exp_a, input bit exp_b);
        load = 1'b1;
        v    = W'(val);
        if (exp_a) push_exp(1'b0, val, cyc + 1 + W);
        if (exp_b) push_exp(1'b1, val, cyc + 1 + W);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_conv(input bit inst_b, input string name);
        exp_t        e;
        int          n;
        logic        vld;
        logic [11:0] got;
        bit          empty;
        n = 0;
        empty = 1'b0;
        do begin
            @(negedge clk);
            n++;
            vld = inst_b ? valid_b : valid_a;
        end while (!vld && n < 40);
        checks++;
        if (!vld) begin
            errors++;
            $display("FAIL %s: no bcd_valid within %0d cycles", name, n);
            return;
        end
        if (inst_b) begin
            if (q_b.size() == 0) empty = 1'b1; else e = q_b.pop_front();
        end else begin
            if (q_a.size() == 0) empty = 1'b1; else e = q_a.pop_front();
        end
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL %s: bcd_valid with no conversion expected at cycle %0d", name, cyc);
            return;
        end
        got = inst_b ? bcd_b : bcd_a;
        checks++;
        if (got !== e.bcd) begin
            errors++;
            $display("FAIL %s_value: bcd got %03h expected %03h", name, got, e.bcd);
        end
        checks++;
        if (cyc !== e.due) begin
            errors++;
            $display("FAIL %s_latency: bcd_valid at cycle %0d expected %0d", name, cyc, e.due);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({count_a, bcd_a, busy_a, run_a, tc_a, valid_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: count=%0d bcd=%03h busy=%b run=%b tc=%b vld=%b expected all 0",
                     count_a, bcd_a, busy_a, run_a, tc_a, valid_a);
        end
        rst_n = 1'b1;
        tick_n(20);
        checks++;
        if (count_a !== 8'd0) begin
            errors++; $display("FAIL idle_count: got %0d expected 0", count_a);
        end
        checks++;
        if (bcd_a !== 12'h000) begin
            errors++; $display("FAIL idle_bcd: got %03h expected 000", bcd_a);
        end
        checks++;
        if (run_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL idle_flags: running=%b busy=%b expected 0 0", run_a, busy_a);
        end
        checks++;
        if (nvalid_a !== 0) begin
            errors++; $display("FAIL idle_valid: %0d bcd_valid pulses expected 0", nvalid_a);
        end
    endtask

    task automatic test_load_idle();
        int nv0;
        nv0 = nvalid_a;
        do_load(123, 1'b1, 1'b0);
        checks++;
        if (count_a !== 8'd123) begin
            errors++; $display("FAIL load_count: got %0d expected 123", count_a);
        end
        tick_n(6);
        checks++;
        if (busy_a !== 1'b1 || bcd_a !== 12'h000) begin
            errors++; $display("FAIL load_busy: busy=%b bcd=%03h expected 1 000", busy_a, bcd_a);
        end
        wait_conv(1'b0, "load_123");
        tick_n(3);
        checks++;
        if (nvalid_a !== nv0 + 1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse: pulses=%0d busy=%b expected %0d 0", nvalid_a - nv0, busy_a, 1);
        end
    endtask

`ifndef COUNTER_CTRL_SATURATE_EN
    task automatic test_wrap();
        int s, tc0;
        do_load(253, 1'b1, 1'b0);
        wait_conv(1'b0, "load_253");
        s   = cyc;
        tc0 = tc_cnt_a;
        start = 1'b1;
        push_exp(1'b0, 254, s + 1 + PA + W);
        push_exp(1'b0, 255, s + 1 + 2*PA + W);
        push_exp(1'b0, 0,   s + 1 + 3*PA + W);
        @(negedge clk);
        start = 1'b0;
        until_cyc(s + PA);
        checks++;
        if (count_a !== 8'd253) begin
            errors++; $display("FAIL wrap_pretick: got %0d expected 253", count_a);
        end
        until_cyc(s + PA + 1);
        checks++;
        if (count_a !== 8'd254 || run_a !== 1'b1) begin
            errors++; $display("FAIL wrap_tick1: count=%0d run=%b expected 254 1", count_a, run_a);
        end
        wait_conv(1'b0, "wrap_254");
        wait_conv(1'b0, "wrap_255");
        until_cyc(s + 3*PA + 2);
        checks++;
        if (count_a !== 8'd0) begin
            errors++; $display("FAIL wrap_count: got %0d expected 0", count_a);
        end
        checks++;
        if (tc_cnt_a !== tc0 + 1 || tc_last_a !== s + 1 + 3*PA) begin
            errors++;
            $display("FAIL wrap_tc: pulses=%0d at %0d expected 1 at %0d",
                     tc_cnt_a - tc0, tc_last_a, s + 1 + 3*PA);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_conv(1'b0, "wrap_000");
        tick_n(12);
        checks++;
        if (run_a !== 1'b0 || count_a !== 8'd0 || tc_cnt_a !== tc0 + 1) begin
            errors++;
            $display("FAIL wrap_stopped: run=%b count=%0d tc_pulses=%0d expected 0 0 1",
                     run_a, count_a, tc_cnt_a - tc0);
        end
    endtask
`else
    task automatic test_saturate();
        int s, s2, tc0, nv0;
        do_load(254, 1'b1, 1'b0);
        wait_conv(1'b0, "sat_load_254");
        s   = cyc;
        tc0 = tc_cnt_a;
        start = 1'b1;
        push_exp(1'b0, 255, s + 1 + PA + W);
        @(negedge clk);
        start = 1'b0;
        wait_conv(1'b0, "sat_255");
        until_cyc(s + 2*PA + 2);
        checks++;
        if (count_a !== 8'd255 || run_a !== 1'b0) begin
            errors++; $display("FAIL sat_hold: count=%0d run=%b expected 255 0", count_a, run_a);
        end
        checks++;
        if (tc_cnt_a !== tc0 + 1 || tc_last_a !== s + 1 + 2*PA) begin
            errors++;
            $display("FAIL sat_tc: pulses=%0d at %0d expected 1 at %0d",
                     tc_cnt_a - tc0, tc_last_a, s + 1 + 2*PA);
        end
        nv0 = nvalid_a;
        tick_n(12);
        checks++;
        if (nvalid_a !== nv0 || bcd_a !== 12'h255) begin
            errors++; $display("FAIL sat_quiet: pulses=%0d bcd=%03h expected 0 255", nvalid_a - nv0, bcd_a);
        end
        s2 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        until_cyc(s2 + PA + 2);
        checks++;
        if (tc_cnt_a !== tc0 + 2 || count_a !== 8'd255 || run_a !== 1'b0) begin
            errors++;
            $display("FAIL sat_resume: tc_pulses=%0d count=%0d run=%b expected 2 255 0",
                     tc_cnt_a - tc0, count_a, run_a);
        end
    endtask
`endif

    task automatic test_collision();
        int s, nv0;
        do_load(10, 1'b0, 1'b1);
        wait_conv(1'b1, "b_load_10");
        s   = cyc;
        nv0 = nvalid_b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        until_cyc(s + 10);
        checks++;
        if (busy_b !== 1'b1 || bcd_b !== 12'h010) begin
            errors++; $display("FAIL coll_mid: busy=%b bcd=%03h expected 1 010", busy_b, bcd_b);
        end
        until_cyc(s + 20);
        checks++;
        if (nvalid_b !== nv0 || bcd_b !== 12'h010) begin
            errors++;
            $display("FAIL coll_stale: pulses=%0d bcd=%03h expected 0 010", nvalid_b - nv0, bcd_b);
        end
        stop = 1'b1;
        push_exp(1'b1, 20, s + 21 + W);
        @(negedge clk);
        stop = 1'b0;
        wait_conv(1'b1, "coll_final");
        checks++;
        if (count_b !== 8'd20 || run_b !== 1'b0) begin
            errors++; $display("FAIL coll_count: count=%0d run=%b expected 20 0", count_b, run_b);
        end
        tick_n(10);
        checks++;
        if (nvalid_b !== nv0 + 1) begin
            errors++; $display("FAIL coll_pulses: got %0d expected 1", nvalid_b - nv0);
        end
    endtask

    task automatic test_cmd_priority();
        do_load(50, 1'b1, 1'b0);
        wait_conv(1'b0, "prio_load_50");
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (run_a !== 1'b0) begin
            errors++; $display("FAIL start_stop: running=%b expected 0", run_a);
        end
        tick_n(15);
        checks++;
        if (count_a !== 8'd50 || run_a !== 1'b0) begin
            errors++; $display("FAIL start_stop_hold: count=%0d run=%b expected 50 0", count_a, run_a);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick_n(3);
        checks++;
        if (run_a !== 1'b1) begin
            errors++; $display("FAIL prio_run: running=%b expected 1", run_a);
        end
        load = 1'b1;
        stop = 1'b1;
        v    = 8'd99;
        push_exp(1'b0, 99, cyc + 1 + W);
        @(negedge clk);
        load = 1'b0;
        stop = 1'b0;
        checks++;
        if (count_a !== 8'd99 || run_a !== 1'b0) begin
            errors++; $display("FAIL load_stop: count=%0d run=%b expected 99 0", count_a, run_a);
        end
        wait_conv(1'b0, "load_stop_99");
        tick_n(12);
        checks++;
        if (count_a !== 8'd99) begin
            errors++; $display("FAIL load_stop_hold: got %0d expected 99", count_a);
        end
        do_load(99, 1'b1, 1'b0);
        wait_conv(1'b0, "reload_same");
    endtask

    task automatic test_reset_mid();
        int nv0;
        do_load(77, 1'b1, 1'b0);
        tick_n(3);
        q_a.delete();
        q_b.delete();
        nv0 = nvalid_a;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || bcd_a !== 12'h000 || count_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b bcd=%03h count=%0d expected 0 000 0", busy_a, bcd_a, count_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick_n(12);
        checks++;
        if (nvalid_a !== nv0 || bcd_a !== 12'h000 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: pulses=%0d bcd=%03h busy=%b expected 0 000 0",
                     nvalid_a - nv0, bcd_a, busy_a);
        end
    endtask

    initial begin
        test_reset();
        test_load_idle();
`ifdef COUNTER_CTRL_SATURATE_EN
        test_saturate();
`else
        test_wrap();
`endif
        test_collision();
        test_cmd_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
